// File: rtl/bf_bus_pkg.sv
// bf_bus_pkg: shared mode, bus phase and width definitions for the BF memory bus.
package bf_bus_pkg;
  typedef enum logic {MODE_LOAD, MODE_RUN} mode_e;
  localparam int BF_DATA_W = 8;
  localparam int BF_EXT_W = 6;
  localparam logic [1:0] PH_ADDR = 2'b11;
  localparam logic [1:0] PH_WDATA = 2'b10;
  function automatic logic is_read(input logic [1:0] ph);
    return !ph[1];
  endfunction
endpackage

// File: rtl/bf_out_fifo.sv
// bf_out_fifo: synchronous FIFO; a push while full is accepted only alongside a pop.
module bf_out_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW:0] wr_q, wr_d, rd_q, rd_d;
  logic do_push, do_pop;
  always_comb begin
    empty = wr_q == rd_q;
    full = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    dout = mem[rd_q[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wr_q[AW-1:0]] <= din;
endmodule

// File: rtl/bf_mem_responder.sv
// bf_mem_responder: BF bus memory with host loader; MMIO output FIFO when MMIO_OUT_EN is defined.
module bf_mem_responder
  import bf_bus_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter logic [7:0] MMIO_ADDR = 8'hFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 bus_write,
  input  logic                 bus_addr,
  input  logic [BF_EXT_W-1:0]  bus_ext,
  input  logic [BF_DATA_W-1:0] bus_din,
  output logic [BF_DATA_W-1:0] bus_dout,
  output logic                 bus_oe,
  output logic                 cpu_hold,
  input  logic                 ld_start,
  input  logic                 ld_valid,
  input  logic [BF_DATA_W-1:0] ld_data,
  output logic                 ld_ready,
  input  logic                 ld_done,
  output logic                 out_valid,
  output logic [BF_DATA_W-1:0] out_data,
  input  logic                 out_ready,
  output logic                 out_ovf
);
  localparam int DEPTH = 1 << ADDR_W;
  logic [BF_DATA_W-1:0] mem [DEPTH];
  mode_e mode_q, mode_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ram_wa;
  logic [ADDR_W:0] ld_ptr_q, ld_ptr_d;
  logic [BF_EXT_W+BF_DATA_W-1:0] full_addr;
  logic [BF_DATA_W-1:0] ram_wd, rd_data;
  logic [1:0] ph;
  logic run, ld_acc, wdata, ram_we, is_mmio, unused_ext;
  assign ph = {bus_write, bus_addr};
  assign full_addr = {bus_ext, bus_din};
  assign unused_ext = ^full_addr;
  always_comb begin
    run = mode_q == MODE_RUN;
    cpu_hold = rst || !run;
    ld_ready = !run && !ld_ptr_q[ADDR_W];
    ld_acc = ld_valid && ld_ready && !ld_start && !rst;
    wdata = run && !rst && ph == PH_WDATA;
    bus_oe = run && !rst && is_read(ph);
    addr_d = (run && ph == PH_ADDR) ? full_addr[ADDR_W-1:0] : addr_q;
    ld_ptr_d = ld_start ? '0 : ld_ptr_q + (ADDR_W+1)'(ld_acc);
    mode_d = ld_start ? MODE_LOAD : (!run && ld_done) ? MODE_RUN : mode_q;
    ram_we = ld_acc || (wdata && !is_mmio);
    ram_wa = run ? addr_q : ld_ptr_q[ADDR_W-1:0];
    ram_wd = run ? bus_din : ld_data;
    bus_dout = bus_oe ? rd_data : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_LOAD;
      addr_q <= '0;
      ld_ptr_q <= '0;
    end else begin
      mode_q <= mode_d;
      addr_q <= addr_d;
      ld_ptr_q <= ld_ptr_d;
    end
  end
  always_ff @(posedge clk)
    if (ram_we) mem[ram_wa] <= ram_wd;
`ifdef MMIO_OUT_EN
  logic fifo_full, fifo_empty, push, pop, ovf_q, ovf_d;
  always_comb begin
    is_mmio = addr_q == ADDR_W'(MMIO_ADDR);
    out_valid = !fifo_empty;
    pop = out_valid && out_ready;
    push = wdata && is_mmio;
    ovf_d = ld_start ? 1'b0 : ovf_q || (push && fifo_full && !pop);
    out_ovf = ovf_q;
    rd_data = is_mmio ? {6'b0, ovf_q, fifo_full} : mem[addr_q];
  end
  always_ff @(posedge clk)
    ovf_q <= rst ? 1'b0 : ovf_d;
  bf_out_fifo #(.DEPTH(FIFO_DEPTH), .W(BF_DATA_W)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .din(bus_din),
    .dout(out_data), .full(fifo_full), .empty(fifo_empty)
  );
`else
  logic unused_out_ready;
  assign unused_out_ready = out_ready;
  assign is_mmio = 1'b0;
  assign out_valid = 1'b0;
  assign out_data = '0;
  assign out_ovf = 1'b0;
  assign rd_data = mem[addr_q];
`endif
endmodule

// File: tb/tb_bf_mem_responder.sv
// tb_bf_mem_responder: directed bench; MMIO checks run when MMIO_OUT_EN is defined.
module tb_bf_mem_responder;
  logic clk = 0, rst = 1;
  logic bus_write = 0, bus_addr = 0;
  logic [5:0] bus_ext = 0;
  logic [7:0] bus_din = 0, ld_data = 0;
  logic ld_start = 0, ld_valid = 0, ld_done = 0, out_ready = 0;
  logic [7:0] bus_dout, out_data;
  logic bus_oe, cpu_hold, ld_ready, out_valid, out_ovf;
  int n_cmp = 0, n_bad = 0;
  always #5 clk = ~clk;
  bf_mem_responder dut (
    .clk(clk), .rst(rst), .bus_write(bus_write), .bus_addr(bus_addr), .bus_ext(bus_ext),
    .bus_din(bus_din), .bus_dout(bus_dout), .bus_oe(bus_oe), .cpu_hold(cpu_hold),
    .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .ld_done(ld_done), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .out_ovf(out_ovf)
  );
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start;
    ld_start = 1; tick; ld_start = 0;
  endtask
  task automatic pulse_done;
    ld_done = 1; tick; ld_done = 0;
  endtask
  task automatic ld_byte(input logic [7:0] d);
    ld_valid = 1; ld_data = d; tick; ld_valid = 0;
  endtask
  task automatic addr_ph(input logic [5:0] e, input logic [7:0] a);
    bus_write = 1; bus_addr = 1; bus_ext = e; bus_din = a; tick;
    bus_write = 0; bus_addr = 0;
  endtask
  task automatic wr_ph(input logic [7:0] d);
    bus_write = 1; bus_addr = 0; bus_din = d; tick;
    bus_write = 0;
  endtask
  task automatic rd_chk(input string tag, input logic [7:0] exp);
    bus_write = 0; #1;
    check(tag, bus_dout, exp);
    tick;
  endtask
  initial begin
    int acc;
    logic [7:0] b;
    tick; tick; #1;
    check("rst cpu_hold", cpu_hold, 1);
    check("rst ld_ready", ld_ready, 1);
    check("rst bus_oe", bus_oe, 0);
    check("rst bus_dout", bus_dout, 0);
    check("rst out_valid", out_valid, 0);
    check("rst out_ovf", out_ovf, 0);
    rst = 0;
    pulse_start;
    ld_byte(8'h2B); ld_byte(8'h2E); ld_byte(8'h5B);
    check("t1 hold before done", cpu_hold, 1);
    pulse_done;
    check("t1 hold after done", cpu_hold, 0);
    rd_chk("t3 ram0 no addr", 8'h2B);
    wr_ph(8'h77);
    rd_chk("t3 ram0 written", 8'h77);
    addr_ph(6'h00, 8'h01); rd_chk("t1 ram1", 8'h2E);
    addr_ph(6'h00, 8'h02); rd_chk("t1 ram2", 8'h5B);
    addr_ph(6'h3F, 8'h01); rd_chk("t3 ext alias", 8'h2E);
    addr_ph(6'h00, 8'h10); wr_ph(8'hA5);
    bus_write = 0; #1;
    check("t2 bus_oe", bus_oe, 1);
    check("t2 read after write", bus_dout, 8'hA5);
    tick;
    rd_chk("t2 addr held", 8'hA5);
    addr_ph(6'h00, 8'h00); rd_chk("t2 ram0 intact", 8'h77);
`ifdef MMIO_OUT_EN
    addr_ph(6'h00, 8'hFF);
    for (int i = 0; i < 5; i++) wr_ph(8'hC0 + 8'(i));
    check("t5 out_valid", out_valid, 1);
    check("t5 out_ovf", out_ovf, 1);
    rd_chk("t5 status full+ovf", 8'h03);
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      check("t5 pop valid", out_valid, 1);
      check("t5 pop data", out_data, 8'hC0 + 8'(i));
      tick;
    end
    out_ready = 0;
    check("t5 drained", out_valid, 0);
    rd_chk("t5 status ovf only", 8'h02);
    pulse_start; pulse_done;
    check("t5 ovf cleared", out_ovf, 0);
    for (int i = 0; i < 4; i++) wr_ph(8'hD0 + 8'(i));
    rd_chk("t5 status full", 8'h01);
    out_ready = 1; wr_ph(8'hD4); out_ready = 0;
    check("t5 push+pop no ovf", out_ovf, 0);
    check("t5 head after pop", out_data, 8'hD1);
    rd_chk("t5 still full", 8'h01);
`else
    addr_ph(6'h00, 8'hFF); wr_ph(8'hC3);
    rd_chk("t5 ff is ram", 8'hC3);
    check("t5 out_valid off", out_valid, 0);
    check("t5 out_data off", out_data, 0);
    check("t5 out_ovf off", out_ovf, 0);
`endif
    addr_ph(6'h00, 8'h20); wr_ph(8'h11);
    bus_write = 1; bus_addr = 0; bus_din = 8'h99; rst = 1;
    tick;
    rst = 0; bus_write = 0; #1;
    check("t6 cpu_hold", cpu_hold, 1);
    check("t6 bus_oe", bus_oe, 0);
    check("t6 ld_ready", ld_ready, 1);
    tick;
    pulse_done;
    addr_ph(6'h00, 8'h20); rd_chk("t6 ram kept", 8'h11);
    pulse_start;
    acc = 0;
    ld_valid = 1;
    for (int i = 0; i < 259; i++) begin
      b = (i < 256) ? (8'(i) ^ 8'h5A) : 8'hEE;
      ld_data = b; #1;
      if (ld_ready) acc++;
      tick;
    end
    ld_valid = 0;
    check("t4 accepted", 16'(acc), 16'd256);
    check("t4 ld_ready low", ld_ready, 0);
    pulse_done;
    addr_ph(6'h00, 8'h00); rd_chk("t4 ram0 not wrapped", 8'h5A);
    addr_ph(6'h00, 8'h01); rd_chk("t4 ram1", 8'h5B);
    addr_ph(6'h00, 8'hFE); rd_chk("t4 ramFE", 8'hA4);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
